// File: rtl/prog_run_ctrl.sv
// Run controller for the 3BC program counter: loads a program entry address,
// gates PC advance by stall/branch/halt from decode, and stops on halt or
// watchdog expiry while reporting the retired-instruction count.
module prog_run_ctrl #(
    parameter int           L        = 10,
    parameter logic [L-1:0] P0_ADDR  = L'(0),
    parameter logic [L-1:0] P1_ADDR  = L'(256),
    parameter logic [L-1:0] P2_ADDR  = L'(512),
    parameter logic [L-1:0] P3_ADDR  = L'(768),
    parameter int           CW       = 16,
    parameter int           TIMEOUT  = 4096
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [1:0]    ProgSel,
    input  logic          HaltReq,
    input  logic          Stall,
    input  logic          BrTaken,
    input  logic [L-1:0]  BrTarget,
    output logic          PcReset,
    output logic          PcEn,
    output logic          PcBranchEn,
    output logic [L-1:0]  PcTarget,
    output logic          Busy,
    output logic          Done,
    output logic          TimedOut,
    output logic [CW-1:0] InstrCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [1:0]    sel_reg;
    logic [CW-1:0] wd_cnt;
    logic          go;
    logic          halt_now;
    logic          wd_expire;
    logic [L-1:0]  entry_addr;

    assign go        = ~Stall & ~HaltReq;
    assign halt_now  = HaltReq & ~Stall;
    assign wd_expire = (wd_cnt == WD_LAST);

    // Entry address lookup for the captured program index
    always_comb begin
        entry_addr = P0_ADDR;
        case (sel_reg)
            2'd0:    entry_addr = P0_ADDR;
            2'd1:    entry_addr = P1_ADDR;
            2'd2:    entry_addr = P2_ADDR;
            default: entry_addr = P3_ADDR;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Program select, instruction count, watchdog and timeout flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_reg    <= '0;
            InstrCount <= '0;
            wd_cnt     <= '0;
            TimedOut   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        sel_reg    <= ProgSel;
                        InstrCount <= '0;
                        wd_cnt     <= '0;
                        TimedOut   <= 1'b0;
                    end
                end
                S_RUN: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (go && (InstrCount != '1))
                        InstrCount <= InstrCount + 1'b1;
                    // halt outranks the watchdog when both hit in one cycle
                    if (halt_now)
                        TimedOut <= 1'b0;
                    else if (wd_expire)
                        TimedOut <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state and PC control decode
    always_comb begin
        state_next = state;
        PcReset    = 1'b0;
        PcEn       = 1'b0;
        PcBranchEn = 1'b0;
        PcTarget   = '0;
        case (state)
            S_IDLE: begin
                PcReset = 1'b1;
                if (Start)
                    state_next = S_LOAD;
            end
            S_LOAD: begin
                PcEn       = 1'b1;
                PcBranchEn = 1'b1;
                PcTarget   = entry_addr;
                state_next = S_RUN;
            end
            S_RUN: begin
                PcEn       = go;
                PcBranchEn = go & BrTaken;
                PcTarget   = BrTarget;
                if (halt_now || wd_expire)
                    state_next = S_DONE;
            end
            S_DONE: begin
                if (Start)
                    state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign Busy = (state == S_LOAD) || (state == S_RUN);
    assign Done = (state == S_DONE);

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl with a small behavioural PC alongside.
module tb_prog_run_ctrl;

    localparam int L  = 10;
    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [1:0]    ProgSel;
    logic          HaltReq;
    logic          Stall;
    logic          BrTaken;
    logic [L-1:0]  BrTarget;
    logic          PcReset;
    logic          PcEn;
    logic          PcBranchEn;
    logic [L-1:0]  PcTarget;
    logic          Busy;
    logic          Done;
    logic          TimedOut;
    logic [CW-1:0] InstrCount;

    logic [L-1:0]  pc;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    prog_run_ctrl #(
        .L       (L),
        .CW      (CW),
        .TIMEOUT (8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .ProgSel    (ProgSel),
        .HaltReq    (HaltReq),
        .Stall      (Stall),
        .BrTaken    (BrTaken),
        .BrTarget   (BrTarget),
        .PcReset    (PcReset),
        .PcEn       (PcEn),
        .PcBranchEn (PcBranchEn),
        .PcTarget   (PcTarget),
        .Busy       (Busy),
        .Done       (Done),
        .TimedOut   (TimedOut),
        .InstrCount (InstrCount)
    );

    always #5 Clk = ~Clk;

    // Program counter driven by the controller outputs
    always @(posedge Clk) begin
        if (PcReset)
            pc <= '0;
        else if (PcEn)
            pc <= PcBranchEn ? PcTarget : pc + 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic launch(input logic [1:0] sel);
        Start   = 1'b1;
        ProgSel = sel;
        step();
        Start   = 1'b0;
        step();
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        ProgSel  = 2'd0;
        HaltReq  = 1'b0;
        Stall    = 1'b0;
        BrTaken  = 1'b0;
        BrTarget = '0;
        step(2);
        Reset = 1'b0;
        #1;
        check_eq("rst_busy",    Busy, 0);
        check_eq("rst_done",    Done, 0);
        check_eq("rst_pcreset", PcReset, 1);
        check_eq("rst_icount",  InstrCount, 0);
        check_eq("rst_timeout", TimedOut, 0);
        check_eq("rst_pc",      pc, 0);

        // Load program 2
        Start   = 1'b1;
        ProgSel = 2'd2;
        step();
        Start = 1'b0;
        #1;
        check_eq("load_en",     PcEn, 1);
        check_eq("load_bren",   PcBranchEn, 1);
        check_eq("load_target", PcTarget, 512);
        check_eq("load_busy",   Busy, 1);
        step();
        check_eq("run_pc_entry", pc, 512);
        check_eq("run_bren",     PcBranchEn, 0);
        check_eq("run_en",       PcEn, 1);

        // Five advances then halt
        step(5);
        check_eq("run5_pc", pc, 517);
        HaltReq = 1'b1;
        #1;
        check_eq("halt_en", PcEn, 0);
        step();
        HaltReq = 1'b0;
        check_eq("halt_done",    Done, 1);
        check_eq("halt_busy",    Busy, 0);
        check_eq("halt_icount",  InstrCount, 5);
        check_eq("halt_timeout", TimedOut, 0);
        step(10);
        check_eq("hold_pc",   pc, 517);
        check_eq("hold_done", Done, 1);
        check_eq("hold_cnt",  InstrCount, 5);

        // Branch then stalls on program 0
        launch(2'd0);
        check_eq("p0_pc", pc, 0);
        BrTaken  = 1'b1;
        BrTarget = 10'd40;
        #1;
        check_eq("br_bren",   PcBranchEn, 1);
        check_eq("br_target", PcTarget, 40);
        step();
        BrTaken = 1'b0;
        check_eq("br_pc", pc, 40);
        Stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_en", PcEn, 0);
            step();
            check_eq("stall_pc", pc, 40);
        end
        Stall = 1'b0;
        step();
        check_eq("post_stall_pc",  pc, 41);
        check_eq("post_stall_cnt", InstrCount, 2);
        HaltReq = 1'b1;
        step();
        HaltReq = 1'b0;
        check_eq("br_done", Done, 1);
        check_eq("br_cnt",  InstrCount, 2);

        // Watchdog expiry after 8 RUN cycles
        launch(2'd3);
        check_eq("p3_pc", pc, 768);
        step(7);
        check_eq("wd7_done", Done, 0);
        check_eq("wd7_busy", Busy, 1);
        step();
        check_eq("wd8_done",    Done, 1);
        check_eq("wd8_timeout", TimedOut, 1);
        check_eq("wd8_cnt",     InstrCount, 8);
        check_eq("wd8_pc",      pc, 776);

        // Halt on the 8th cycle outranks the watchdog
        launch(2'd3);
        check_eq("wdr_timeout_clr", TimedOut, 0);
        step(7);
        HaltReq = 1'b1;
        step();
        HaltReq = 1'b0;
        check_eq("wdh_done",    Done, 1);
        check_eq("wdh_timeout", TimedOut, 0);
        check_eq("wdh_cnt",     InstrCount, 7);

        // Halt held off by stall; restart from DONE with program 1
        launch(2'd1);
        check_eq("p1_pc", pc, 256);
        step(2);
        HaltReq = 1'b1;
        Stall   = 1'b1;
        step(2);
        check_eq("hs_done", Done, 0);
        check_eq("hs_cnt",  InstrCount, 2);
        check_eq("hs_pc",   pc, 258);
        Stall = 1'b0;
        step();
        HaltReq = 1'b0;
        check_eq("hs_done_after", Done, 1);
        check_eq("hs_cnt_after",  InstrCount, 2);
        check_eq("hs_timeout",    TimedOut, 0);

        // Start ignored in RUN; reset mid-RUN
        launch(2'd0);
        step();
        Start   = 1'b1;
        ProgSel = 2'd2;
        step(2);
        Start = 1'b0;
        check_eq("ign_busy", Busy, 1);
        check_eq("ign_cnt",  InstrCount, 3);
        check_eq("ign_pc",   pc, 3);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_eq("mid_rst_busy",    Busy, 0);
        check_eq("mid_rst_pcreset", PcReset, 1);
        check_eq("mid_rst_cnt",     InstrCount, 0);
        check_eq("mid_rst_done",    Done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
